// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register for the pipelined RV32I core, with the
// load-use hazard detector folded in.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   *D                  control word and datapath fields from decode
//   FlushE              kill the instruction entering EX (taken branch/jump)
//   StallE              hold EX contents (downstream memory stall)
//   *E                  registered copies of the decode fields
//   ValidE              EX holds a real instruction, not a bubble
//   StallF, StallD      hold PC and IF/ID register (combinational)
//   LoadUseCnt          saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [2:0]       Funct3D,
    input  logic             FlushE,
    input  logic             StallE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [2:0]       Funct3E,
    output logic             ValidE,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] LoadUseCnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic [2:0]      mem_write;
        logic            jump;
        logic            branch;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_t              ex_q;
    ex_t              ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_e_s;
    logic             hazard_s;

    // Load-use detection from the registered EX state against the decode sources.
    // Rs2D is compared for every opcode, which may stall needlessly but never misses.
    always_comb begin
        load_e_s = ex_q.valid & (ex_q.result_src == 2'b01);
        hazard_s = load_e_s & (ex_q.rd != 5'd0) &
                   ((ex_q.rd == Rs1D) | (ex_q.rd == Rs2D));
        // A flush kills the consumer anyway, so a hazard must not stall under it.
        StallF   = (hazard_s & ~FlushE) | StallE;
        StallD   = (hazard_s & ~FlushE) | StallE;
    end

    // Next EX contents and counter: hold > flush bubble > hazard bubble > capture.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (StallE) begin
            ex_d  = ex_q;
            cnt_d = cnt_q;
        end else if (FlushE) begin
            ex_d  = '0;
            cnt_d = cnt_q;
        end else if (hazard_s) begin
            ex_d = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ex_d.valid       = 1'b1;
            ex_d.reg_write   = RegWriteD;
            ex_d.result_src  = ResultSrcD;
            ex_d.mem_write   = MemWriteD;
            ex_d.jump        = JumpD;
            ex_d.branch      = BranchD;
            ex_d.alu_control = ALUControlD;
            ex_d.alu_src     = ALUSrcD;
            ex_d.rd1         = RD1D;
            ex_d.rd2         = RD2D;
            ex_d.pc          = PCD;
            ex_d.pc_plus4    = PCPlus4D;
            ex_d.imm_ext     = ImmExtD;
            ex_d.rs1         = Rs1D;
            ex_d.rs2         = Rs2D;
            ex_d.rd          = RdD;
            ex_d.funct3      = Funct3D;
        end
    end

    // EX pipeline register and load-use counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ALUControlE = ex_q.alu_control;
    assign ALUSrcE     = ex_q.alu_src;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign ImmExtE     = ex_q.imm_ext;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign Funct3E     = ex_q.funct3;
    assign LoadUseCnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. A driver issues one decode word per
// cycle, advances an instruction-level reference model and pushes the
// expected stall level and post-edge EX contents. A monitor pops each entry
// and compares it with the DUT. The DUT counter is 4 bits wide so that
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [2:0]  mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } d_t;

    typedef struct packed {
        logic valid;
        d_t   d;
    } e_t;

    typedef struct {
        logic       stall;
        e_t         e;
        logic [3:0] cnt;
        logic       chk_now;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    d_t   din = '0;
    logic flush_e = 1'b0;
    logic stall_e = 1'b0;

    logic       RegWriteE, JumpE, BranchE, ALUSrcE, ValidE, StallF, StallD;
    logic [1:0] ResultSrcE;
    logic [2:0] MemWriteE, ALUControlE, Funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [3:0] LoadUseCnt;

    e_t act;

    item_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // reference model state: the instruction currently in EX and the bubble count
    e_t m_ex  = '0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(din.reg_write), .ResultSrcD(din.result_src), .MemWriteD(din.mem_write),
        .JumpD(din.jump), .BranchD(din.branch), .ALUControlD(din.alu_control),
        .ALUSrcD(din.alu_src), .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc),
        .PCPlus4D(din.pc_plus4), .ImmExtD(din.imm_ext), .Rs1D(din.rs1), .Rs2D(din.rs2),
        .RdD(din.rd), .Funct3D(din.funct3), .FlushE(flush_e), .StallE(stall_e),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD), .LoadUseCnt(LoadUseCnt)
    );

    // gather DUT outputs into the comparison record
    always_comb begin
        act = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
               ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E};
    end

    function automatic d_t rand_d();
        d_t r;
        r.reg_write   = 1'($urandom_range(0, 1));
        r.result_src  = 2'($urandom_range(0, 3));
        r.mem_write   = 3'($urandom_range(0, 7));
        r.jump        = 1'($urandom_range(0, 1));
        r.branch      = 1'($urandom_range(0, 1));
        r.alu_control = 3'($urandom_range(0, 7));
        r.alu_src     = 1'($urandom_range(0, 1));
        r.rd1         = $urandom;
        r.rd2         = $urandom;
        r.pc          = $urandom;
        r.pc_plus4    = r.pc + 32'd4;
        r.imm_ext     = $urandom;
        r.rs1         = 5'($urandom_range(0, 7));
        r.rs2         = 5'($urandom_range(0, 7));
        r.rd          = 5'($urandom_range(0, 7));
        r.funct3      = 3'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic d_t mk(input logic [1:0] rsrc, input logic regw, input logic [2:0] memw,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        d_t r;
        r            = rand_d();
        r.result_src = rsrc;
        r.reg_write  = regw;
        r.mem_write  = memw;
        r.rs1        = rs1;
        r.rs2        = rs2;
        r.rd         = rd;
        return r;
    endfunction

    // One cycle of stimulus: drive between edges, advance the model, queue expectations.
    task automatic cycle(input d_t d, input logic fl, input logic st, input logic rn);
        item_t it;
        bit    is_load;
        bit    uses;
        bit    hz;
        @(negedge clk);
        din     = d;
        flush_e = fl;
        stall_e = st;
        rst_n   = rn;
        #2;
        if (!rn) begin
            m_ex  = '0;
            m_cnt = 0;
        end
        is_load = m_ex.valid && (m_ex.d.result_src == 2'b01);
        uses    = (m_ex.d.rd != 5'd0) && (m_ex.d.rd == d.rs1 || m_ex.d.rd == d.rs2);
        hz      = is_load && uses;
        it.stall   = (hz && !fl) || st;
        it.chk_now = !rn;
        if (!rn) begin
            m_ex = '0;
        end else if (st) begin
            m_ex = m_ex;
        end else if (fl || hz) begin
            m_ex = '0;
            if (!fl && m_cnt < 15) m_cnt = m_cnt + 1;
        end else begin
            m_ex.valid = 1'b1;
            m_ex.d     = d;
        end
        it.e   = m_ex;
        it.cnt = 4'(m_cnt);
        exp_q.push_back(it);
    endtask

    // Monitor: after the driver has settled the inputs, check stalls; after the edge, check EX.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                total++;
                if (StallF !== it.stall || StallD !== it.stall) begin
                    bad++;
                    $display("FAIL stall act=%b/%b exp=%b", StallF, StallD, it.stall);
                end
                if (it.chk_now) begin
                    total++;
                    if (act !== '0 || LoadUseCnt !== 4'd0) begin
                        bad++;
                        $display("FAIL async_reset act=%h cnt=%h exp=0", act, LoadUseCnt);
                    end
                end
                @(posedge clk);
                #1;
                total++;
                if (act !== it.e) begin
                    bad++;
                    $display("FAIL ex_state act=%h exp=%h", act, it.e);
                end
                total++;
                if (LoadUseCnt !== it.cnt) begin
                    bad++;
                    $display("FAIL load_use_cnt act=%h exp=%h", LoadUseCnt, it.cnt);
                end
            end
        end
    end

    initial begin
        d_t lw, add, addi, sw, x;
        // reset
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1, 1'b0);
        // pass-through ADDI
        addi = mk(2'b00, 1'b1, 3'b000, 5'd1, 5'd2, 5'd3);
        addi.alu_src = 1'b1;
        addi.imm_ext = 32'h5;
        cycle(addi, 1'b0, 1'b0, 1'b1);
        // load-use: LW x5, then ADD reading x5 (held once, then captured)
        lw  = mk(2'b01, 1'b1, 3'b000, 5'd2, 5'd7, 5'd5);
        add = mk(2'b00, 1'b1, 3'b000, 5'd5, 5'd6, 5'd8);
        cycle(lw, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b0, 1'b0, 1'b1);
        // load to x0: no stall
        lw.rd = 5'd0;
        add.rs1 = 5'd0;
        cycle(lw, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b0, 1'b0, 1'b1);
        // flush of a store
        sw = mk(2'b00, 1'b0, 3'b001, 5'd1, 5'd2, 5'd0);
        cycle(sw, 1'b1, 1'b0, 1'b1);
        // flush masks a pending load-use
        lw.rd = 5'd5;
        add.rs1 = 5'd5;
        cycle(lw, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b1, 1'b0, 1'b1);
        // StallE hold for 3 cycles with changing D, then flush held through the stall
        cycle(addi, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(rand_d(), 1'b0, 1'b1, 1'b1);
        cycle(rand_d(), 1'b1, 1'b1, 1'b1);
        cycle(rand_d(), 1'b1, 1'b1, 1'b1);
        cycle(rand_d(), 1'b1, 1'b0, 1'b1);
        // StallE with a hazard pending: hold without counting, then bubble
        cycle(lw, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b0, 1'b1, 1'b1);
        cycle(add, 1'b0, 1'b0, 1'b1);
        cycle(add, 1'b0, 1'b0, 1'b1);
        // reset mid-stream
        cycle(addi, 1'b0, 1'b0, 1'b1);
        cycle(addi, 1'b0, 1'b0, 1'b0);
        cycle(addi, 1'b0, 1'b0, 1'b1);
        // 17 load-use pairs drive the 4-bit counter into saturation
        for (int i = 0; i < 17; i++) begin
            cycle(lw, 1'b0, 1'b0, 1'b1);
            cycle(add, 1'b0, 1'b0, 1'b1);
            cycle(add, 1'b0, 1'b0, 1'b1);
        end
        // randomized traffic with frequent register reuse
        cycle('0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            x = rand_d();
            if ($urandom_range(0, 2) == 0) x.rs1 = m_ex.d.rd;
            cycle(x, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 99) != 0));
        end
        cycle('0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the pipelined RV32I core. It sits directly downstream of the decode control unit and captures that unit's D-stage control word together with the decode datapath fields. It presents them to the execute stage one cycle later. It also contains the load-use hazard detector: it raises decode/fetch stalls and inserts a bubble into EX, and it accepts execute-side flush and stall requests.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating load-use stall counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low (one clock, no other reset)
- RegWriteD, ResultSrcD[1:0], MemWriteD[2:0], JumpD, BranchD, ALUControlD[2:0], ALUSrcD  in  (as named)  control word from decode control unit
- RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  XLEN each  register-file reads, PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  in  5 each  source and destination register indices
- Funct3D  in  3  branch/load type, passed to EX
- FlushE  in  1  branch/jump taken in EX; kill the instruction entering EX
- StallE  in  1  downstream (memory) stall; hold EX contents
- RegWriteE ... ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E  out  same widths as D inputs  registered copies
- ValidE  out  1  EX holds a real instruction (not a bubble)
- StallF, StallD  out  1 each  hold PC and IF/ID register
- LoadUseCnt  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- LoadE = ValidE & (ResultSrcE == 2'b01). Hazard = LoadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)). Rs2D is compared for every opcode; this is deliberately conservative.
- StallF = StallD = (Hazard & ~FlushE) | StallE. These outputs are combinational from the registered E state and the D inputs.
- Per-edge action, highest priority first:
  1. StallE: hold all E registers. FlushE is ignored; the source keeps FlushE asserted until StallE drops.
  2. FlushE: load a bubble.
  3. Hazard: load a bubble. D is held upstream via StallD.
  4. Otherwise: load the D inputs and set ValidE = 1.
- Bubble: every control output is 0 (RegWriteE = 0, MemWriteE = 3'b000, JumpE = 0, BranchE = 0, ResultSrcE = 2'b00, ALUControlE = 3'b000, ALUSrcE = 0). RdE, Rs1E, Rs2E, Funct3E and all XLEN fields are 0. ValidE = 0.
- LoadUseCnt increments by 1 on each edge where a Hazard bubble is loaded (case 3). It saturates at all-ones and never wraps. A flush bubble does not count.
- A back-to-back load followed by its consumer produces exactly one bubble. After the bubble, ValidE = 0, so LoadE = 0 and the stall releases.

## Timing
- Latency: 1 cycle, D inputs to E outputs.
- Reset (rst_n low, asynchronous, at any point in operation): every registered output is 0, including ValidE and LoadUseCnt.
  - StallF/StallD therefore evaluate to StallE during reset.
  - The first capture happens on the first rising edge after rst_n deasserts.
- Hazard stall lasts exactly one cycle per load-use pair, unless StallE extends it.
- FlushE and Hazard in the same cycle: the bubble is loaded, stalls are masked, and the counter does not increment.
- StallE and Hazard in the same cycle: hold, no counter increment. The hazard is re-evaluated on the next unstalled cycle.
- No handshake other than the stall/flush levels. All inputs are sampled on the rising clk edge.

## Test plan
- Reset mid-stream: load ADD fields, then pull rst_n low between edges. All outputs go to 0 immediately (no clock edge needed), ValidE = 0, LoadUseCnt = 0.
- Pass-through: ADDI (RegWriteD = 1, ALUSrcD = 1, ImmExtD = 32'h5, RdD = 3) → next edge RegWriteE = 1, ImmExtE = 32'h5, RdE = 3, ValidE = 1, StallD = 0.
- Load-use: LW with RdD = 5, then ADD with Rs1D = 5.
  - Next cycle: StallF = StallD = 1.
  - Following edge: bubble loaded (ValidE = 0, RegWriteE = 0), LoadUseCnt = 1.
  - Then: ADD captured, stalls = 0.
  - Repeat with RdD = 0: no stall.
- Flush: FlushE = 1 while decode presents SW (MemWriteD = 3'b001) → MemWriteE = 0, ValidE = 0, counter unchanged.
  - With LW in E and a dependent instruction in D while FlushE = 1: StallD = 0, counter unchanged.
- StallE hold: StallE = 1 for 3 cycles while the D inputs change → E outputs constant, StallF = StallD = 1.
  - FlushE asserted during StallE is ignored until StallE = 0, then the bubble is loaded.
- Counter saturation: with CNT_W = 4, generate 17 load-use pairs → LoadUseCnt stops at 4'hF.
